// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt controller slice.
package irq_pkg;

   localparam int unsigned NUM_IRQ_SOURCES = 6;

   typedef enum logic [1:0] {
      StIdle,
      StReq,
      StHoldoff
   } irq_state_e;

   localparam logic [2:0] IDX_PROG_TIMER  = 3'd0;
   localparam logic [2:0] IDX_SERIAL      = 3'd1;
   localparam logic [2:0] IDX_K0          = 3'd2;
   localparam logic [2:0] IDX_K1          = 3'd3;
   localparam logic [2:0] IDX_STOPWATCH   = 3'd4;
   localparam logic [2:0] IDX_CLOCK_TIMER = 3'd5;
   localparam logic [2:0] IDX_NMI         = 3'd6;

   localparam logic [3:0] VEC_PROG_TIMER  = 4'hC;
   localparam logic [3:0] VEC_SERIAL      = 4'hA;
   localparam logic [3:0] VEC_K0          = 4'h8;
   localparam logic [3:0] VEC_K1          = 4'h6;
   localparam logic [3:0] VEC_STOPWATCH   = 4'h4;
   localparam logic [3:0] VEC_CLOCK_TIMER = 4'h2;
   localparam logic [3:0] VEC_NMI         = 4'h0;

   function automatic logic [3:0] source_vector(input logic [2:0] idx);
      case (idx)
         IDX_PROG_TIMER:  return VEC_PROG_TIMER;
         IDX_SERIAL:      return VEC_SERIAL;
         IDX_K0:          return VEC_K0;
         IDX_K1:          return VEC_K1;
         IDX_STOPWATCH:   return VEC_STOPWATCH;
         IDX_CLOCK_TIMER: return VEC_CLOCK_TIMER;
         IDX_NMI:         return VEC_NMI;
         default:         return VEC_NMI;
      endcase
   endfunction

endpackage

// File: rtl/irq_controller_if.sv
// CPU-side interrupt handshake: request/vector/busy out, acknowledge and I flag in.
interface irq_controller_if;

   logic       interrupt_enable;
   logic       irq_ack;
   logic       irq_req;
   logic [3:0] irq_vector;
   logic       irq_busy;

   modport master (
      input  interrupt_enable,
      input  irq_ack,
      output irq_req,
      output irq_vector,
      output irq_busy
   );

   modport slave (
      output interrupt_enable,
      output irq_ack,
      input  irq_req,
      input  irq_vector,
      input  irq_busy
   );

endinterface

// File: rtl/irq_priority_enc.sv
// Fixed-priority encoder: lowest set bit of pending wins (bit0 highest priority).
module irq_priority_enc
   import irq_pkg::*;
(
   input  logic [NUM_IRQ_SOURCES-1:0] pending,
   output logic                       valid,
   output logic [2:0]                 index,
   output logic [3:0]                 vector
);

   always_comb begin
      valid = 1'b0;
      index = IDX_PROG_TIMER;
      // Scan downwards so the lowest pending bit is the last one written.
      for (int i = int'(NUM_IRQ_SOURCES) - 1; i >= 0; i--) begin
         if (pending[i]) begin
            valid = 1'b1;
            index = 3'(i);
         end
      end
      vector = source_vector(index);
   end

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: masked factor flags -> one latched request with REQ/HOLDOFF flow.
// Optional watchdog NMI input is enabled by defining IRQ_WATCHDOG_NMI_EN.
module irq_controller
   import irq_pkg::*;
#(
   parameter int unsigned HOLDOFF_CYCLES = 2
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic [NUM_IRQ_SOURCES-1:0] factor_flags,
   input  logic [NUM_IRQ_SOURCES-1:0] mask,
`ifdef IRQ_WATCHDOG_NMI_EN
   input  logic                       watchdog_nmi,
`endif
   irq_controller_if.master           cpu
);

   localparam logic [3:0] HOLDOFF_LOAD = 4'(HOLDOFF_CYCLES);

   irq_state_e                 state_q;
   logic [3:0]                 holdoff_q;
   logic [2:0]                 index_q;
   logic [3:0]                 vector_q;
   logic                       req_q;
   logic                       busy_q;

   logic [NUM_IRQ_SOURCES-1:0] pending;
   logic [7:0]                 pending_ext;
   logic                       win_valid;
   logic [2:0]                 win_index;
   logic [3:0]                 win_vector;
   logic                       start_req;
   logic [2:0]                 start_index;
   logic [3:0]                 start_vector;
   logic                       no_withdraw;
   logic                       withdraw;

   assign pending     = factor_flags & mask;
   assign pending_ext = {{(8 - NUM_IRQ_SOURCES){1'b0}}, pending};

   irq_priority_enc u_priority_enc (
      .pending (pending),
      .valid   (win_valid),
      .index   (win_index),
      .vector  (win_vector)
   );

`ifdef IRQ_WATCHDOG_NMI_EN
   assign start_req    = watchdog_nmi | (cpu.interrupt_enable & win_valid);
   assign start_index  = watchdog_nmi ? IDX_NMI : win_index;
   assign start_vector = watchdog_nmi ? VEC_NMI : win_vector;
   assign no_withdraw  = (index_q == IDX_NMI);
`else
   assign start_req    = cpu.interrupt_enable & win_valid;
   assign start_index  = win_index;
   assign start_vector = win_vector;
   assign no_withdraw  = 1'b0;
`endif

   assign withdraw = !no_withdraw && (!cpu.interrupt_enable || !pending_ext[index_q]);

   // HOLDOFF re-arbitrates directly once the counter is 0, so irq_req stays low for
   // HOLDOFF_CYCLES+1 cycles after an acknowledge.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= StIdle;
         holdoff_q <= 4'd0;
         index_q   <= 3'd0;
         vector_q  <= 4'h0;
         req_q     <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start_req) begin
                  state_q  <= StReq;
                  index_q  <= start_index;
                  vector_q <= start_vector;
                  req_q    <= 1'b1;
                  busy_q   <= 1'b1;
               end
            end
            StReq: begin
               if (cpu.irq_ack) begin
                  state_q   <= StHoldoff;
                  holdoff_q <= HOLDOFF_LOAD;
                  req_q     <= 1'b0;
               end else if (withdraw) begin
                  state_q <= StIdle;
                  req_q   <= 1'b0;
                  busy_q  <= 1'b0;
               end
            end
            StHoldoff: begin
               if (holdoff_q != 4'd0) begin
                  holdoff_q <= holdoff_q - 4'd1;
               end else if (start_req) begin
                  state_q  <= StReq;
                  index_q  <= start_index;
                  vector_q <= start_vector;
                  req_q    <= 1'b1;
               end else begin
                  state_q <= StIdle;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= StIdle;
               req_q   <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign cpu.irq_req    = req_q;
   assign cpu.irq_vector = vector_q;
   assign cpu.irq_busy   = busy_q;

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: directed scenarios plus randomized traffic
// checked every cycle against a behavioural model.
module tb_irq_controller;

   localparam int unsigned HOLDOFF = 2;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [5:0] factor_flags;
   logic [5:0] mask;
   logic       nmi_now;

   always #5 clk = ~clk;

   irq_controller_if cpu_if ();

`ifdef IRQ_WATCHDOG_NMI_EN
   logic watchdog_nmi;
   assign nmi_now = watchdog_nmi;
`else
   assign nmi_now = 1'b0;
`endif

   irq_controller #(
      .HOLDOFF_CYCLES (HOLDOFF)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .factor_flags (factor_flags),
      .mask         (mask),
`ifdef IRQ_WATCHDOG_NMI_EN
      .watchdog_nmi (watchdog_nmi),
`endif
      .cpu          (cpu_if)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
   endtask

   // Model: a request is either live (m_req) or blocked for m_gap more cycles after ack.
   bit         m_valid = 1'b0;
   bit         m_req   = 1'b0;
   bit         m_busy  = 1'b0;
   bit         m_vec_known = 1'b0;
   logic [3:0] m_vec   = 4'h0;
   int         m_src   = 0;
   int         m_gap   = 0;

   always @(posedge clk) begin : model
      logic [5:0] p;
      int         win;
      p   = factor_flags & mask;
      win = -1;
      for (int i = 5; i >= 0; i--) if (p[i]) win = i;
      if (!reset_n) begin
         m_valid = 1'b1;
         m_req = 1'b0; m_busy = 1'b0; m_vec = 4'h0; m_gap = 0; m_vec_known = 1'b1;
      end else if (m_valid) begin
         if (m_req) begin
            if (cpu_if.irq_ack) begin
               m_req = 1'b0; m_gap = int'(HOLDOFF) + 1; m_vec_known = 1'b0;
            end else if (m_src >= 0 && (!cpu_if.interrupt_enable || !p[m_src])) begin
               m_req = 1'b0; m_busy = 1'b0; m_vec_known = 1'b0;
            end
         end else if (m_gap > 1) begin
            m_gap--;
         end else begin
            m_gap = 0;
            if (nmi_now) begin
               m_req = 1'b1; m_src = -1; m_vec = 4'h0; m_busy = 1'b1;
            end else if (cpu_if.interrupt_enable && win >= 0) begin
               m_req = 1'b1; m_src = win; m_vec = 4'(12 - 2 * win); m_busy = 1'b1;
            end else begin
               m_busy = 1'b0;
            end
         end
      end
      #1;
      if (m_valid) begin
         check("model_req", 4'(cpu_if.irq_req), 4'(m_req));
         check("model_busy", 4'(cpu_if.irq_busy), 4'(m_busy));
         if (m_req || m_vec_known) check("model_vector", cpu_if.irq_vector, m_vec);
      end
   end

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic set_nmi(input logic v);
`ifdef IRQ_WATCHDOG_NMI_EN
      watchdog_nmi = v;
`else
      if (v) $display("note: NMI stimulus ignored in this build");
`endif
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      factor_flags = 6'h00;
      mask = 6'h3F;
      cpu_if.interrupt_enable = 1'b1;
      cpu_if.irq_ack = 1'b0;
      set_nmi(1'b0);
      cyc();
      cyc();
      check("rst_req", 4'(cpu_if.irq_req), 4'h0);
      check("rst_busy", 4'(cpu_if.irq_busy), 4'h0);
      check("rst_vector", cpu_if.irq_vector, 4'h0);
      reset_n = 1'b1;
   endtask

   task automatic pulse_ack();
      cpu_if.irq_ack = 1'b1;
      cyc();
      cpu_if.irq_ack = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0;
      factor_flags = 6'h00;
      mask = 6'h00;
      cpu_if.interrupt_enable = 1'b0;
      cpu_if.irq_ack = 1'b0;
      set_nmi(1'b0);

      // Bit0 rises after ten idle cycles: request one cycle later with vector C.
      do_reset();
      repeat (9) cyc();
      check("s1_idle_req", 4'(cpu_if.irq_req), 4'h0);
      factor_flags = 6'b000001;
      cyc();
      check("s1_req", 4'(cpu_if.irq_req), 4'h1);
      check("s1_vector", cpu_if.irq_vector, 4'hC);

      // Vector frozen while in REQ even when a higher-priority source appears.
      do_reset();
      factor_flags = 6'b110000;
      cyc();
      check("s2_vector", cpu_if.irq_vector, 4'h4);
      factor_flags = 6'b110001;
      cyc();
      check("s2_frozen_req", 4'(cpu_if.irq_req), 4'h1);
      check("s2_frozen_vec", cpu_if.irq_vector, 4'h4);
      pulse_ack();
      check("s2_ack_req", 4'(cpu_if.irq_req), 4'h0);

      // Holdoff after ack with bit3 still pending.
      do_reset();
      factor_flags = 6'b001000;
      cyc();
      check("s3_vector", cpu_if.irq_vector, 4'h6);
      pulse_ack();
      check("s3_n1_req", 4'(cpu_if.irq_req), 4'h0);
      check("s3_n1_busy", 4'(cpu_if.irq_busy), 4'h1);
      cyc();
      check("s3_n2_req", 4'(cpu_if.irq_req), 4'h0);
      cyc();
      check("s3_n3_req", 4'(cpu_if.irq_req), 4'h0);
      cyc();
      check("s3_n4_req", 4'(cpu_if.irq_req), 4'h1);
      check("s3_n4_vec", cpu_if.irq_vector, 4'h6);

      // Withdraw on mask drop; later ack ignored.
      do_reset();
      factor_flags = 6'b100000;
      cyc();
      check("s4_vector", cpu_if.irq_vector, 4'h2);
      mask = 6'h1F;
      cyc();
      check("s4_wd_req", 4'(cpu_if.irq_req), 4'h0);
      check("s4_wd_busy", 4'(cpu_if.irq_busy), 4'h0);
      pulse_ack();
      check("s4_ack_req", 4'(cpu_if.irq_req), 4'h0);
      check("s4_ack_busy", 4'(cpu_if.irq_busy), 4'h0);

      // Reset during HOLDOFF, then re-request after release.
      do_reset();
      factor_flags = 6'b001000;
      cyc();
      pulse_ack();
      check("s5_hold_busy", 4'(cpu_if.irq_busy), 4'h1);
      reset_n = 1'b0;
      cyc();
      check("s5_req", 4'(cpu_if.irq_req), 4'h0);
      check("s5_busy", 4'(cpu_if.irq_busy), 4'h0);
      check("s5_vector", cpu_if.irq_vector, 4'h0);
      reset_n = 1'b1;
      cyc();
      check("s5_rearm_vec", cpu_if.irq_vector, 4'h6);

      // I flag gating, priority and withdraw on I drop.
      do_reset();
      cpu_if.interrupt_enable = 1'b0;
      factor_flags = 6'b010110;
      cyc();
      check("s6_gated_req", 4'(cpu_if.irq_req), 4'h0);
      cpu_if.interrupt_enable = 1'b1;
      cyc();
      check("s6_prio_vec", cpu_if.irq_vector, 4'hA);
      cpu_if.interrupt_enable = 1'b0;
      cyc();
      check("s6_wd_req", 4'(cpu_if.irq_req), 4'h0);

`ifdef IRQ_WATCHDOG_NMI_EN
      do_reset();
      cpu_if.interrupt_enable = 1'b0;
      mask = 6'h00;
      watchdog_nmi = 1'b1;
      cyc();
      check("nmi_req", 4'(cpu_if.irq_req), 4'h1);
      check("nmi_vec", cpu_if.irq_vector, 4'h0);
      watchdog_nmi = 1'b0;
      cyc();
      check("nmi_held", 4'(cpu_if.irq_req), 4'h1);
      pulse_ack();
      check("nmi_ack", 4'(cpu_if.irq_req), 4'h0);
`endif

      // Randomized traffic; the model process checks every cycle.
      do_reset();
      repeat (3000) begin
         cyc();
         for (int b = 0; b < 6; b++)
            if ($urandom_range(0, 7) == 0) factor_flags[b] = ~factor_flags[b];
         if ($urandom_range(0, 31) == 0)
            mask = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'h3F;
         cpu_if.interrupt_enable = ($urandom_range(0, 9) != 0);
         cpu_if.irq_ack = (m_req && $urandom_range(0, 2) == 0) || ($urandom_range(0, 15) == 0);
`ifdef IRQ_WATCHDOG_NMI_EN
         if ($urandom_range(0, 63) == 0) watchdog_nmi = ~watchdog_nmi;
`endif
         reset_n = ($urandom_range(0, 299) != 0);
      end
      cyc();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/irq_controller.md
IRQ_CONTROLLER -- requirements
Module: irq_controller

Interface
REQ-001 The block SHALL have parameter HOLDOFF_CYCLES, default 2, meaning the number of idle cycles enforced after an acknowledge before a new request is raised (legal range 1..15).
REQ-002 The block SHALL have port clk, input, 1, the single system clock.
REQ-003 The block SHALL have port reset_n, input, 1, a synchronous active-low reset.
REQ-004 The block SHALL have port factor_flags, input, 6, the raw interrupt factor flags with this bit mapping:
  - bit0 prog timer
  - bit1 serial
  - bit2 K00-K03
  - bit3 K10
  - bit4 stopwatch
  - bit5 clock timer
REQ-005 The block SHALL have port mask, input, 6, the per-source enable bits (1 = enabled), bitwise aligned with factor_flags.
REQ-006 The block SHALL have port interrupt_enable, input, 1, the CPU I flag.
REQ-007 The block SHALL have port irq_ack, input, 1, a one-cycle acknowledge from the CPU.
REQ-008 The block SHALL have port irq_req, output, 1, the interrupt request to the CPU.
REQ-009 The block SHALL have port irq_vector, output, 4, the vector low nibble, valid whenever irq_req=1.
REQ-010 The block SHALL have port irq_busy, output, 1, which is high in the REQ and HOLDOFF states.

Function
REQ-011 The block SHALL compute pending = factor_flags & mask each cycle.
REQ-012 The block SHALL use fixed priority with bit0 highest and bit5 lowest.
REQ-013 The block SHALL map vectors as follows: bit0=0xC, bit1=0xA, bit2=0x8, bit3=0x6, bit4=0x4, bit5=0x2.
REQ-014 The block SHALL implement an FSM with exactly three states: IDLE, REQ and HOLDOFF.
REQ-015 In IDLE, when interrupt_enable=1 and pending!=0 at cycle n, the block SHALL latch the winning source index and vector and SHALL enter REQ, so that irq_req=1 is visible at cycle n+1 (one-cycle latency).
REQ-016 In REQ, irq_vector SHALL stay frozen, even if a higher-priority source becomes pending.
REQ-017 In REQ, if the latched source's pending bit drops or interrupt_enable drops before irq_ack, the block SHALL withdraw: irq_req low next cycle, return to IDLE, and re-arbitrate normally.
REQ-018 In REQ, irq_ack=1 SHALL move the block to HOLDOFF with irq_req low next cycle and the holdoff counter loaded with HOLDOFF_CYCLES.
REQ-019 If irq_ack and a withdraw condition occur in the same cycle, the acknowledge SHALL win.
REQ-020 The HOLDOFF counter SHALL decrement once per cycle; the block SHALL return to IDLE in the cycle after the counter reaches 0, with no wrap-around.
REQ-021 The block SHALL ignore irq_ack in IDLE and in HOLDOFF.
REQ-022 The block SHALL never clear factor flags; flag clearing remains with the source blocks (for example, the reset_factor strobe of the prog timer).

Reset
REQ-023 While reset_n=0 at a clk edge, the block SHALL load these values:
  - state=IDLE
  - irq_req=0
  - irq_vector=0x0
  - irq_busy=0
  - holdoff counter=0
  - latched index=0
REQ-024 Assertion of reset_n=0 in any state SHALL abort the current request in the same edge; no request SHALL be raised in the first cycle after reset releases.

Configuration
REQ-025 When macro IRQ_WATCHDOG_NMI_EN is defined, the block SHALL add input port watchdog_nmi (1 bit, level).
REQ-026 With IRQ_WATCHDOG_NMI_EN defined, watchdog_nmi SHALL have priority over all sources, SHALL ignore mask and interrupt_enable, SHALL use vector 0x0, and SHALL follow the same REQ/HOLDOFF flow.
REQ-027 With IRQ_WATCHDOG_NMI_EN defined, an NMI latched in REQ SHALL never be withdrawn.
REQ-028 Without IRQ_WATCHDOG_NMI_EN, the watchdog_nmi port and its logic SHALL be absent and behaviour SHALL be exactly as in REQ-011..REQ-022.

Structure
REQ-029 Shared package irq_pkg SHALL hold:
  - the state enum
  - source index constants
  - the vector constants (0x0..0xC)
  - NUM_IRQ_SOURCES=6
REQ-030 The block SHALL use one sub-module, irq_priority_enc, a combinational fixed-priority encoder (pending -> valid, index, vector).

Verification
REQ-031 Scenario: reset released, mask=6'h3F, I=1; factor_flags bit0 rises at cycle 10 -> irq_req=1 at cycle 11 with vector=0xC.
REQ-032 Scenario: flags=6'b110000, mask=6'h3F -> vector=0x4; bit0 rises during REQ -> vector stays 0x4 until irq_ack.
REQ-033 Scenario: HOLDOFF_CYCLES=2; ack at cycle n while bit3 is still pending -> irq_req=0 for cycles n+1..n+3, then irq_req=1 with vector 0x6 at n+4.
REQ-034 Scenario: in REQ for bit5, mask[5] cleared before ack -> irq_req=0 next cycle and state=IDLE; a later irq_ack is ignored.
REQ-035 Scenario: reset_n=0 during HOLDOFF -> next cycle irq_req=0, irq_busy=0, vector=0x0, state=IDLE.
REQ-036 Scenario (IRQ_WATCHDOG_NMI_EN defined): I=0, mask=0, watchdog_nmi=1 -> irq_req=1 with vector=0x0; dropping watchdog_nmi before ack does not withdraw the request.
